// File: rtl/stopwatch_pkg.sv
`default_nettype none
// stopwatch_pkg: shared state encoding and clock/tick constants for the stopwatch control stage.
// Rev 1.0
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam int CLK_HZ            = 100_000_000;
  localparam int TICK_HZ           = 100;
  localparam int DEFAULT_DIV       = CLK_HZ / TICK_HZ;
  localparam int DEFAULT_DB_CYCLES = 1_000_000;

  // Width of a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// stopwatch_ctrl_if: button inputs and counter-chain control outputs of the stopwatch control stage.
// Rev 1.0
interface stopwatch_ctrl_if;

  logic btn_startstop;
  logic btn_clear;
  logic tick_enb;
  logic clr;
  logic running;

  modport master (
    output btn_startstop,
    output btn_clear,
    input  tick_enb,
    input  clr,
    input  running
  );

  modport slave (
    input  btn_startstop,
    input  btn_clear,
    output tick_enb,
    output clr,
    output running
  );

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// btn_debounce: 2-flop synchroniser, stable-level debouncer and registered rising-edge press pulse.
// Rev 1.0
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      // Any sample agreeing with the accepted level restarts the stability window.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// stopwatch_ctrl: debounced start/stop and clear buttons driving an IDLE/RUN/PAUSE FSM and tick prescaler.
// Rev 1.0
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV       = DEFAULT_DIV,
  parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  stopwatch_ctrl_if.slave bus
);

  localparam int            PW         = cnt_width(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic ss_level;
  logic ss_press;
  logic clr_level;
  logic clr_press;
  logic unused_levels;

  sw_state_t     state;
  sw_state_t     state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic          clr_q;
  logic          running_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_startstop (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_startstop),
    .level   (ss_level),
    .press   (ss_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_clear),
    .level   (clr_level),
    .press   (clr_press)
  );

  assign unused_levels = ss_level ^ clr_level;

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;

    case (state)
      IDLE:    if (ss_press) state_nxt = RUN;
      RUN:     if (ss_press) state_nxt = PAUSE;
      PAUSE:   if (ss_press) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    // Clear wins over a simultaneous start/stop press.
    if (clr_press) state_nxt = IDLE;

    // PAUSE simply holds, preserving the fractional tick.
    if (clr_press || (state == IDLE)) begin
      presc_nxt = '0;
    end else if (state == RUN) begin
      presc_nxt = (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      clr_q     <= clr_press;
      running_q <= (state == RUN);
    end
  end

  assign bus.tick_enb = (state == RUN) && (presc == PRESC_LAST);
  assign bus.clr      = clr_q;
  assign bus.running  = running_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// tb_stopwatch_ctrl: directed button scenarios against a history-based behavioural model of the stopwatch control.
// Rev 1.0
module tb_stopwatch_ctrl;

  localparam int DIV = 4;
  localparam int DB  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   t = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: raw samples kept per edge; a button level is accepted once the
  // synchronised view (two edges late) has disagreed for DB edges in a row.
  bit hist [2][64];
  int n_idx;
  int since [2];
  bit acc [2];
  bit rose [2];
  bit m_press [2];
  int m_state;  // 0 idle, 1 run, 2 pause
  int m_presc;
  bit m_clr;
  bit m_run;
  bit m_valid = 1'b0;

  function automatic bit synced(input int b, input int idx);
    return hist[b][((idx % 64) + 64) % 64];
  endfunction

  always @(posedge clk) begin
    bit raw [2];
    bit old_ss;
    bit old_cl;
    bit all_diff;
    raw[0] = bus.btn_startstop;
    raw[1] = bus.btn_clear;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        hist[b][0] = 1'b0;
        hist[b][1] = 1'b0;
        since[b]   = 0;
        acc[b]     = 1'b0;
        rose[b]    = 1'b0;
        m_press[b] = 1'b0;
      end
      n_idx   = 2;
      m_state = 0;
      m_presc = 0;
      m_clr   = 1'b0;
      m_run   = 1'b0;
      m_valid = 1'b1;
    end else begin
      old_ss = m_press[0];
      old_cl = m_press[1];
      m_clr  = old_cl;
      m_run  = (m_state == 1);
      if (old_cl || m_state == 0) m_presc = 0;
      else if (m_state == 1)      m_presc = (m_presc + 1) % DIV;
      if (old_cl)      m_state = 0;
      else if (old_ss) m_state = (m_state == 1) ? 2 : 1;
      for (int b = 0; b < 2; b++) begin
        m_press[b] = rose[b];
        hist[b][n_idx % 64] = raw[b];
        since[b]++;
        all_diff = (since[b] >= DB);
        if (all_diff)
          for (int k = 0; k < DB; k++)
            if (synced(b, n_idx - 2 - k) == acc[b]) all_diff = 1'b0;
        rose[b] = 1'b0;
        if (all_diff) begin
          acc[b]   = ~acc[b];
          since[b] = 0;
          rose[b]  = acc[b];
        end
      end
      n_idx++;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model tick_enb", bus.tick_enb, (m_state == 1) && (m_presc == DIV - 1));
      chk("model clr", bus.clr, m_clr);
      chk("model running", bus.running, m_run);
      chk("tick/clr exclusive", bus.tick_enb & bus.clr, 1'b0);
    end
  end

  task automatic goto(input int k);
    while (t < k) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    bus.btn_startstop = 1'b0;
    bus.btn_clear     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset running", bus.running, 1'b0);
    chk("reset clr", bus.clr, 1'b0);
    chk("reset tick", bus.tick_enb, 1'b0);

    // Long start/stop press: one pulse, RUN, ticks every DIV cycles.
    bus.btn_startstop = 1'b1;
    goto(7);  chk("t1 running late", bus.running, 1'b0);
    goto(8);  chk("t1 running", bus.running, 1'b1);
              chk("t1 no early tick", bus.tick_enb, 1'b0);
    goto(10); chk("t1 first tick", bus.tick_enb, 1'b1);
              bus.btn_startstop = 1'b0;
    goto(11); chk("t1 tick one cycle", bus.tick_enb, 1'b0);
    goto(14); chk("t1 second tick", bus.tick_enb, 1'b1);

    // Pause with prescaler at 2, then resume.
    goto(22); bus.btn_startstop = 1'b1;
    goto(26); chk("t2 tick before pause", bus.tick_enb, 1'b1);
    goto(27); bus.btn_startstop = 1'b0;
    goto(29); chk("t2 running lag", bus.running, 1'b1);
    goto(30); chk("t2 paused", bus.running, 1'b0);
              chk("t2 paused tick", bus.tick_enb, 1'b0);
    goto(36); chk("t2 paused hold", bus.tick_enb, 1'b0);
    goto(40); bus.btn_startstop = 1'b1;
    goto(45); bus.btn_startstop = 1'b0;
    goto(47); chk("t2 resume no tick", bus.tick_enb, 1'b0);
    goto(48); chk("t2 resume tick", bus.tick_enb, 1'b1);
              chk("t2 resume running", bus.running, 1'b1);
    goto(49); chk("t2 tick drop", bus.tick_enb, 1'b0);
    goto(52); chk("t2 next tick", bus.tick_enb, 1'b1);

    // Short glitch is rejected.
    goto(60); bus.btn_startstop = 1'b1;
    goto(62); bus.btn_startstop = 1'b0;
    goto(70); chk("t3 glitch ignored", bus.running, 1'b1);

    // Clear while running.
    goto(80); bus.btn_clear = 1'b1;
    goto(85); bus.btn_clear = 1'b0;
    goto(86); chk("t4 clr early", bus.clr, 1'b0);
    goto(87); chk("t4 clr pulse", bus.clr, 1'b1);
              chk("t4 clr no tick", bus.tick_enb, 1'b0);
    goto(88); chk("t4 clr one cycle", bus.clr, 1'b0);
              chk("t4 cleared running", bus.running, 1'b0);

    // Restart from cleared prescaler, then pause.
    goto(100); bus.btn_startstop = 1'b1;
    goto(105); bus.btn_startstop = 1'b0;
    goto(108); chk("t5 run again", bus.running, 1'b1);
    goto(110); chk("t5 tick from zero", bus.tick_enb, 1'b1);
    goto(120); bus.btn_startstop = 1'b1;
    goto(125); bus.btn_startstop = 1'b0;
    goto(128); chk("t5 paused", bus.running, 1'b0);

    // Simultaneous presses from PAUSE: clear wins.
    goto(140); bus.btn_startstop = 1'b1; bus.btn_clear = 1'b1;
    goto(145); bus.btn_startstop = 1'b0; bus.btn_clear = 1'b0;
    goto(146); chk("t5 both clr early", bus.clr, 1'b0);
    goto(147); chk("t5 both clr", bus.clr, 1'b1);
               chk("t5 both running", bus.running, 1'b0);
    goto(148); chk("t5 both clr once", bus.clr, 1'b0);
    goto(150); chk("t5 stays idle", bus.running, 1'b0);
               chk("t5 idle tick", bus.tick_enb, 1'b0);

    // Reset mid-RUN with the button still held.
    goto(160); bus.btn_startstop = 1'b1;
    goto(175); chk("t6 running", bus.running, 1'b1);
    goto(180); rst = 1'b1;
    goto(181); rst = 1'b0;
               chk("t6 rst running", bus.running, 1'b0);
               chk("t6 rst clr", bus.clr, 1'b0);
               chk("t6 rst tick", bus.tick_enb, 1'b0);
    goto(188); chk("t6 repress late", bus.running, 1'b0);
    goto(189); chk("t6 repress", bus.running, 1'b1);
    goto(195); bus.btn_startstop = 1'b0;
    goto(220);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
